pipe_id_exe_stage: RTL and testbench

//  ID/EXE pipeline register plus EXE-side operand forwarding for the 5-stage pipelined CPU.

---
 rtl/pipe_id_exe_stage_pkg.sv | 48 ++++
 rtl/pipe_id_exe_stage_if.sv | 55 +++++
 rtl/pipe_id_exe_stage_fwd_mux.sv | 29 ++
 rtl/pipe_id_exe_stage.sv | 116 +++++++++++
 tb/tb_pipe_id_exe_stage.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_id_exe_stage_pkg.sv
// Shared definitions for the ID/EXE stage: ALU opcodes and the EXE control word.
package pipe_id_exe_stage_pkg;

  localparam logic [3:0] ALUC_ADD  = 4'b0000;
  localparam logic [3:0] ALUC_SUB  = 4'b0100;
  localparam logic [3:0] ALUC_AND  = 4'b0001;
  localparam logic [3:0] ALUC_OR   = 4'b0101;
  localparam logic [3:0] ALUC_XOR  = 4'b0010;
  localparam logic [3:0] ALUC_LUI  = 4'b0110;
  localparam logic [3:0] ALUC_SLL  = 4'b0011;
  localparam logic [3:0] ALUC_SRL  = 4'b0111;
  localparam logic [3:0] ALUC_SRA  = 4'b1111;
  localparam logic [3:0] ALUC_HAMM = 4'b1011;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       aluimm;
    logic       shift;
    logic       jal;
    logic [3:0] aluc;
  } ctrl_t;

  // A bubble does nothing anywhere downstream.
  localparam ctrl_t BUBBLE = '0;

  function automatic ctrl_t make_ctrl(
    input logic       wreg,
    input logic       m2reg,
    input logic       wmem,
    input logic       aluimm,
    input logic       shift,
    input logic       jal,
    input logic [3:0] aluc
  );
    ctrl_t c;
    c.wreg   = wreg;
    c.m2reg  = m2reg;
    c.wmem   = wmem;
    c.aluimm = aluimm;
    c.shift  = shift;
    c.jal    = jal;
    c.aluc   = aluc;
    return c;
  endfunction

endpackage

// File: rtl/pipe_id_exe_stage_if.sv
// Bundle of ID inputs, MEM/WB bypass inputs and EXE outputs of the ID/EXE stage.
interface pipe_id_exe_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          flush;
  logic          d_wreg;
  logic          d_m2reg;
  logic          d_wmem;
  logic          d_aluimm;
  logic          d_shift;
  logic          d_jal;
  logic [3:0]    d_aluc;
  logic [RW-1:0] d_rs;
  logic [RW-1:0] d_rt;
  logic [RW-1:0] d_rn;
  logic [DW-1:0] d_qa;
  logic [DW-1:0] d_qb;
  logic [DW-1:0] d_imm;
  logic [4:0]    d_sa;
  logic [DW-1:0] d_pc4;
  logic          m_wreg;
  logic [RW-1:0] m_rn;
  logic [DW-1:0] m_res;
  logic          w_wreg;
  logic [RW-1:0] w_rn;
  logic [DW-1:0] w_data;
  logic          stall;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_aluc;
  logic          e_wreg;
  logic          e_m2reg;
  logic          e_wmem;
  logic          e_jal;
  logic [RW-1:0] e_rn;
  logic [DW-1:0] e_sdata;
  logic [DW-1:0] e_pc8;

  modport master (
    output flush, d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal, d_aluc,
           d_rs, d_rt, d_rn, d_qa, d_qb, d_imm, d_sa, d_pc4,
           m_wreg, m_rn, m_res, w_wreg, w_rn, w_data,
    input  stall, alu_a, alu_b, alu_aluc, e_wreg, e_m2reg, e_wmem, e_jal,
           e_rn, e_sdata, e_pc8
  );

  modport slave (
    input  flush, d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal, d_aluc,
           d_rs, d_rt, d_rn, d_qa, d_qb, d_imm, d_sa, d_pc4,
           m_wreg, m_rn, m_res, w_wreg, w_rn, w_data,
    output stall, alu_a, alu_b, alu_aluc, e_wreg, e_m2reg, e_wmem, e_jal,
           e_rn, e_sdata, e_pc8
  );
endinterface

// File: rtl/pipe_id_exe_stage_fwd_mux.sv
// Operand bypass: picks MEM result, then WB data, else the register-file value.
module fwd_mux #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] q,
  input  logic          m_wreg,
  input  logic [RW-1:0] m_rn,
  input  logic [DW-1:0] m_res,
  input  logic          w_wreg,
  input  logic [RW-1:0] w_rn,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] fwd
);

  // Register 0 is hard-wired, so it is never bypassed.
  always_comb begin
    fwd = q;
    if (src != '0) begin
      if (m_wreg && (m_rn == src)) begin
        fwd = m_res;
      end else if (w_wreg && (w_rn == src)) begin
        fwd = w_data;
      end
    end
  end

endmodule

// File: rtl/pipe_id_exe_stage.sv
// ID/EXE pipeline register with EXE operand forwarding and load-use stall detection.
module pipe_id_exe_stage
  import pipe_id_exe_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic               clock,
  input  logic               reset,
  pipe_id_exe_stage_if.slave bus
);

  ctrl_t         ctrl_reg, ctrl_next;
  logic [RW-1:0] rs_reg, rs_next;
  logic [RW-1:0] rt_reg, rt_next;
  logic [RW-1:0] rn_reg, rn_next;
  logic [DW-1:0] qa_reg, qa_next;
  logic [DW-1:0] qb_reg, qb_next;
  logic [DW-1:0] imm_reg, imm_next;
  logic [4:0]    sa_reg, sa_next;
  logic [DW-1:0] pc8_reg, pc8_next;
  logic          stall_int;
  logic          load_en;

  logic [RW-1:0] src_sel [2];
  logic [DW-1:0] q_sel   [2];
  logic [DW-1:0] fwd_val [2];

  // The instruction in EXE is a load whose result the ID instruction needs now.
  assign stall_int = ctrl_reg.m2reg && (rn_reg != '0) &&
                     ((rn_reg == bus.d_rs) || (rn_reg == bus.d_rt));
  assign load_en   = !(bus.flush || stall_int);

  always_comb begin
    ctrl_next = BUBBLE;
    rs_next   = '0;
    rt_next   = '0;
    rn_next   = '0;
    qa_next   = '0;
    qb_next   = '0;
    imm_next  = '0;
    sa_next   = '0;
    pc8_next  = '0;
    if (load_en) begin
      ctrl_next = make_ctrl(bus.d_wreg, bus.d_m2reg, bus.d_wmem, bus.d_aluimm,
                            bus.d_shift, bus.d_jal, bus.d_aluc);
      rs_next   = bus.d_rs;
      rt_next   = bus.d_rt;
      rn_next   = bus.d_rn;
      qa_next   = bus.d_qa;
      qb_next   = bus.d_qb;
      imm_next  = bus.d_imm;
      sa_next   = bus.d_sa;
      pc8_next  = bus.d_pc4 + {{(DW-3){1'b0}}, 3'd4};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_reg <= BUBBLE;
      rs_reg   <= '0;
      rt_reg   <= '0;
      rn_reg   <= '0;
      qa_reg   <= '0;
      qb_reg   <= '0;
      imm_reg  <= '0;
      sa_reg   <= '0;
      pc8_reg  <= '0;
    end else begin
      ctrl_reg <= ctrl_next;
      rs_reg   <= rs_next;
      rt_reg   <= rt_next;
      rn_reg   <= rn_next;
      qa_reg   <= qa_next;
      qb_reg   <= qb_next;
      imm_reg  <= imm_next;
      sa_reg   <= sa_next;
      pc8_reg  <= pc8_next;
    end
  end

  assign src_sel[0] = rs_reg;
  assign src_sel[1] = rt_reg;
  assign q_sel[0]   = qa_reg;
  assign q_sel[1]   = qb_reg;

  // Index 0 bypasses the rs operand, index 1 the rt operand.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_mux #(.DW(DW), .RW(RW)) u_fwd (
        .src    (src_sel[gi]),
        .q      (q_sel[gi]),
        .m_wreg (bus.m_wreg),
        .m_rn   (bus.m_rn),
        .m_res  (bus.m_res),
        .w_wreg (bus.w_wreg),
        .w_rn   (bus.w_rn),
        .w_data (bus.w_data),
        .fwd    (fwd_val[gi])
      );
    end
  endgenerate

  assign bus.stall    = stall_int;
  assign bus.alu_a    = ctrl_reg.shift  ? {{(DW-5){1'b0}}, sa_reg} : fwd_val[0];
  assign bus.alu_b    = ctrl_reg.aluimm ? imm_reg : fwd_val[1];
  assign bus.alu_aluc = ctrl_reg.aluc;
  assign bus.e_wreg   = ctrl_reg.wreg;
  assign bus.e_m2reg  = ctrl_reg.m2reg;
  assign bus.e_wmem   = ctrl_reg.wmem;
  assign bus.e_jal    = ctrl_reg.jal;
  assign bus.e_rn     = rn_reg;
  assign bus.e_sdata  = fwd_val[1];
  assign bus.e_pc8    = pc8_reg;

endmodule

// File: tb/tb_pipe_id_exe_stage.sv
// Directed and randomized checks of pipe_id_exe_stage against an instruction-level model.
module tb_pipe_id_exe_stage;
  import pipe_id_exe_stage_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pipe_id_exe_stage_if #(.DW(32), .RW(5)) bus ();

  pipe_id_exe_stage #(.DW(32), .RW(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // The instruction the model believes is sitting in EXE.
  typedef struct {
    bit          valid;
    bit          wreg, m2reg, wmem, aluimm, shift, jal;
    logic [3:0]  aluc;
    logic [4:0]  rs, rt, rn, sa;
    logic [31:0] qa, qb, imm, pc4;
  } ins_t;

  ins_t ex;
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic ins_t empty_ins();
    ins_t e;
    e.valid = 0; e.wreg = 0; e.m2reg = 0; e.wmem = 0; e.aluimm = 0;
    e.shift = 0; e.jal = 0; e.aluc = '0; e.rs = '0; e.rt = '0; e.rn = '0;
    e.sa = '0; e.qa = '0; e.qb = '0; e.imm = '0; e.pc4 = '0;
    return e;
  endfunction

  function automatic ins_t from_id();
    ins_t e;
    e.valid = 1; e.wreg = bus.d_wreg; e.m2reg = bus.d_m2reg; e.wmem = bus.d_wmem;
    e.aluimm = bus.d_aluimm; e.shift = bus.d_shift; e.jal = bus.d_jal;
    e.aluc = bus.d_aluc; e.rs = bus.d_rs; e.rt = bus.d_rt; e.rn = bus.d_rn;
    e.sa = bus.d_sa; e.qa = bus.d_qa; e.qb = bus.d_qb; e.imm = bus.d_imm;
    e.pc4 = bus.d_pc4;
    return e;
  endfunction

  function automatic logic [31:0] forward(input logic [4:0] src, input logic [31:0] q);
    if (src == 0) return q;
    if (bus.m_wreg && bus.m_rn == src) return bus.m_res;
    if (bus.w_wreg && bus.w_rn == src) return bus.w_data;
    return q;
  endfunction

  function automatic logic model_stall();
    return ex.m2reg && ex.rn != 0 && (ex.rn == bus.d_rs || ex.rn == bus.d_rt);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("stall",    {31'b0, bus.stall},   {31'b0, model_stall()});
    chk("alu_a",    bus.alu_a,  ex.shift  ? {27'b0, ex.sa} : forward(ex.rs, ex.qa));
    chk("alu_b",    bus.alu_b,  ex.aluimm ? ex.imm : forward(ex.rt, ex.qb));
    chk("alu_aluc", {28'b0, bus.alu_aluc}, {28'b0, ex.aluc});
    chk("e_wreg",   {31'b0, bus.e_wreg},  {31'b0, ex.wreg});
    chk("e_m2reg",  {31'b0, bus.e_m2reg}, {31'b0, ex.m2reg});
    chk("e_wmem",   {31'b0, bus.e_wmem},  {31'b0, ex.wmem});
    chk("e_jal",    {31'b0, bus.e_jal},   {31'b0, ex.jal});
    chk("e_rn",     {27'b0, bus.e_rn},    {27'b0, ex.rn});
    chk("e_sdata",  bus.e_sdata, forward(ex.rt, ex.qb));
    chk("e_pc8",    bus.e_pc8,   ex.valid ? ex.pc4 + 32'd4 : 32'd0);
  endtask

  // Check current state, then apply one clock edge and advance the model.
  task automatic cycle();
    bit bubble;
    #1 check_all();
    $display("t=%0t rst=%b flush=%b d_rs=%0d d_rt=%0d stall=%b alu_a=%h alu_b=%h aluc=%h e_rn=%0d",
             $time, reset, bus.flush, bus.d_rs, bus.d_rt, bus.stall,
             bus.alu_a, bus.alu_b, bus.alu_aluc, bus.e_rn);
    bubble = reset || bus.flush || model_stall();
    @(posedge clock);
    ex = bubble ? empty_ins() : from_id();
    @(negedge clock);
  endtask

  task automatic set_idle();
    bus.flush = 0; bus.d_wreg = 0; bus.d_m2reg = 0; bus.d_wmem = 0; bus.d_aluimm = 0;
    bus.d_shift = 0; bus.d_jal = 0; bus.d_aluc = '0; bus.d_rs = '0; bus.d_rt = '0;
    bus.d_rn = '0; bus.d_qa = '0; bus.d_qb = '0; bus.d_imm = '0; bus.d_sa = '0;
    bus.d_pc4 = '0; bus.m_wreg = 0; bus.m_rn = '0; bus.m_res = '0;
    bus.w_wreg = 0; bus.w_rn = '0; bus.w_data = '0;
  endtask

  task automatic randomize_inputs();
    bus.d_wreg   = 1'($urandom_range(0, 1));
    bus.d_m2reg  = ($urandom_range(0, 2) == 0);
    bus.d_wmem   = 1'($urandom_range(0, 1));
    bus.d_aluimm = 1'($urandom_range(0, 1));
    bus.d_shift  = ($urandom_range(0, 3) == 0);
    bus.d_jal    = ($urandom_range(0, 7) == 0);
    bus.d_aluc   = 4'($urandom_range(0, 15));
    bus.d_rs     = 5'($urandom_range(0, 7));
    bus.d_rt     = 5'($urandom_range(0, 7));
    bus.d_rn     = 5'($urandom_range(0, 7));
    bus.d_qa     = $urandom;
    bus.d_qb     = $urandom;
    bus.d_imm    = $urandom;
    bus.d_sa     = 5'($urandom_range(0, 31));
    bus.d_pc4    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
    bus.m_wreg   = 1'($urandom_range(0, 1));
    bus.m_rn     = 5'($urandom_range(0, 7));
    bus.m_res    = $urandom;
    bus.w_wreg   = 1'($urandom_range(0, 1));
    bus.w_rn     = 5'($urandom_range(0, 7));
    bus.w_data   = $urandom;
    bus.flush    = ($urandom_range(0, 15) == 0);
    reset        = ($urandom_range(0, 31) == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ex = empty_ins();
    reset = 1;
    set_idle();
    bus.d_wreg = 1;
    bus.d_rn = 5'd9;
    @(posedge clock);
    @(negedge clock);
    cycle();
    cycle();
    #1 chk("reset_e_wreg", {31'b0, bus.e_wreg}, 32'd0);
    reset = 0;

    // add with no hazards
    set_idle();
    bus.d_wreg = 1; bus.d_rs = 5'd1; bus.d_qa = 32'd5; bus.d_rt = 5'd2; bus.d_qb = 32'd7;
    bus.d_rn = 5'd3; bus.d_aluc = ALUC_ADD; bus.d_pc4 = 32'h100;
    cycle();
    set_idle();
    #1 chk("add_alu_a", bus.alu_a, 32'd5);
    chk("add_alu_b", bus.alu_b, 32'd7);
    chk("add_e_wreg", {31'b0, bus.e_wreg}, 32'd1);
    chk("add_e_pc8", bus.e_pc8, 32'h104);

    // forwarding priority
    bus.d_wreg = 1; bus.d_rs = 5'd3; bus.d_qa = 32'd1; bus.d_rt = 5'd0; bus.d_rn = 5'd8;
    cycle();
    set_idle();
    bus.m_wreg = 1; bus.m_rn = 5'd3; bus.m_res = 32'h10;
    bus.w_wreg = 1; bus.w_rn = 5'd3; bus.w_data = 32'h20;
    #1 chk("fwd_mem", bus.alu_a, 32'h10);
    bus.m_wreg = 0;
    #1 chk("fwd_wb", bus.alu_a, 32'h20);
    bus.d_rs = 5'd0; bus.d_qa = 32'h55; bus.m_wreg = 1; bus.m_rn = 5'd0; bus.m_res = 32'hDEAD;
    bus.w_rn = 5'd0;
    cycle();
    #1 chk("rs0_no_fwd", bus.alu_a, 32'h55);

    // load-use stall
    set_idle();
    bus.d_wreg = 1; bus.d_m2reg = 1; bus.d_rn = 5'd4; bus.d_rs = 5'd1; bus.d_rt = 5'd2;
    cycle();
    set_idle();
    bus.d_rs = 5'd7; bus.d_rt = 5'd4; bus.d_wmem = 1; bus.d_wreg = 1;
    #1 chk("load_use_stall", {31'b0, bus.stall}, 32'd1);
    cycle();
    #1 chk("bubble_e_wreg", {31'b0, bus.e_wreg}, 32'd0);
    chk("bubble_e_wmem", {31'b0, bus.e_wmem}, 32'd0);
    chk("stall_clears", {31'b0, bus.stall}, 32'd0);
    cycle();

    // flush and stall together give a single bubble
    set_idle();
    bus.d_wreg = 1; bus.d_m2reg = 1; bus.d_rn = 5'd5;
    cycle();
    set_idle();
    bus.d_rs = 5'd5; bus.flush = 1; bus.d_wreg = 1;
    #1 chk("flush_stall", {31'b0, bus.stall}, 32'd1);
    cycle();
    set_idle();
    bus.d_rs = 5'd5; bus.d_wreg = 1; bus.d_shift = 1; bus.d_sa = 5'd31;
    bus.d_aluimm = 1; bus.d_imm = 32'hFFFF_8000; bus.d_aluc = ALUC_HAMM; bus.d_rn = 5'd6;
    #1 chk("single_bubble", {31'b0, bus.stall}, 32'd0);
    cycle();
    #1 chk("shift_alu_a", bus.alu_a, 32'd31);
    chk("imm_alu_b", bus.alu_b, 32'hFFFF_8000);
    chk("hamm_aluc", {28'b0, bus.alu_aluc}, {28'b0, ALUC_HAMM});

    // pc+8 wrap
    set_idle();
    bus.d_wreg = 1; bus.d_jal = 1; bus.d_pc4 = 32'hFFFF_FFFC; bus.d_rn = 5'd31;
    cycle();
    #1 chk("pc8_wrap", bus.e_pc8, 32'h0000_0000);
    chk("jal_e_jal", {31'b0, bus.e_jal}, 32'd1);

    // reset in the middle of a stall
    set_idle();
    bus.d_wreg = 1; bus.d_m2reg = 1; bus.d_rn = 5'd6;
    cycle();
    set_idle();
    bus.d_rs = 5'd6;
    #1 chk("pre_reset_stall", {31'b0, bus.stall}, 32'd1);
    reset = 1;
    cycle();
    #1 chk("reset_stall_off", {31'b0, bus.stall}, 32'd0);
    chk("reset_bubble", {31'b0, bus.e_m2reg}, 32'd0);
    reset = 0;

    for (int i = 0; i < 250; i++) begin
      randomize_inputs();
      cycle();
    end
    reset = 0;
    set_idle();
    #1 check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
